pos_read_controller: RTL and testbench

- Address and phase sequencer directly upstream of pos_data_preprocessor.
- Generates particle_id, ref_id, phase, reading_particle_num and pause_reading, which index the neighbour position caches and steer the preprocessor.
- Runs one home-cell sweep per start pulse: read particle count, then for each reference particle broadcast every neighbour particle over phase 0/1, then drain and report done.
- Stalls on filter back-pressure.

---
 rtl/pos_read_controller_pkg.sv | 16 +
 rtl/pos_read_addr_counter.sv | 70 +++++++
 rtl/pos_read_controller.sv | 158 +++++++++++++++
 tb/tb_pos_read_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_read_controller_pkg.sv
// Shared types for the position read controller.
// State encoding and the count-word cache address.
package pos_read_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_NUM,
        WAIT_CNT,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned COUNT_ADDR = 0;

endpackage

// File: rtl/pos_read_addr_counter.sv
// Nested ref/particle/phase address counter.
// Phase toggles fastest, then particle_id, then ref_id.
module pos_read_addr_counter
    import pos_read_controller_pkg::*;
#(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         init_i,
    input  logic         advance_i,
    input  logic [W-1:0] count_i,
    output logic [W-1:0] particle_id_o,
    output logic [W-1:0] ref_id_o,
    output logic         phase_o,
    output logic         last_pair_o
);

    logic [W-1:0] pid_q, pid_d;
    logic [W-1:0] ref_q, ref_d;
    logic         ph_q, ph_d;

    // Next address: clear to the count word, load (1,1,p0), or step.
    always_comb begin
        pid_d = pid_q;
        ref_d = ref_q;
        ph_d  = ph_q;
        if (clear_i) begin
            pid_d = W'(COUNT_ADDR);
            ref_d = '0;
            ph_d  = 1'b0;
        end else if (init_i) begin
            pid_d = W'(1);
            ref_d = W'(1);
            ph_d  = 1'b0;
        end else if (advance_i) begin
            if (!ph_q) begin
                ph_d = 1'b1;
            end else if (pid_q != count_i) begin
                pid_d = pid_q + W'(1);
                ph_d  = 1'b0;
            end else if (ref_q != count_i) begin
                ref_d = ref_q + W'(1);
                pid_d = W'(1);
                ph_d  = 1'b0;
            end
        end
    end

    // Address registers double as the registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pid_q <= '0;
            ref_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            pid_q <= pid_d;
            ref_q <= ref_d;
            ph_q  <= ph_d;
        end
    end

    assign particle_id_o = pid_q;
    assign ref_id_o      = ref_q;
    assign phase_o       = ph_q;
    assign last_pair_o   = ph_q && (pid_q == count_i)
                                && (ref_q == count_i);

endmodule

// File: rtl/pos_read_controller.sv
// Home-cell sweep sequencer feeding pos_data_preprocessor.
// Address regs hold the next pending read; they step only on issue.
module pos_read_controller
    import pos_read_controller_pkg::*;
#(
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NUM_FILTER        = 7,
    parameter int COUNT_WAIT        = 2,
    parameter int DRAIN_CYCLES      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_FILTER-1:0]        back_pressure,
    input  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count,
    output logic                         phase,
    output logic                         pause_reading,
    output logic                         reading_particle_num,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         busy,
    output logic                         done
);

    localparam int W     = PARTICLE_ID_WIDTH;
    localparam int CMAX  = (COUNT_WAIT > DRAIN_CYCLES)
                         ? COUNT_WAIT : DRAIN_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       count_q, count_d;
    logic               pause_q, pause_d;
    logic               rpn_q, rpn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ctr_clear, ctr_init, ctr_adv;
    logic               last_pair;
    logic               stall;

    assign stall = |back_pressure;

    pos_read_addr_counter #(
        .W (W)
    ) u_addr (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (ctr_clear),
        .init_i        (ctr_init),
        .advance_i     (ctr_adv),
        .count_i       (count_q),
        .particle_id_o (particle_id),
        .ref_id_o      (ref_id),
        .phase_o       (phase),
        .last_pair_o   (last_pair)
    );

    // Next state plus next registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        pause_d   = 1'b1;
        rpn_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ctr_clear = 1'b0;
        ctr_init  = 1'b0;
        ctr_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d    = 1'b0;
                ctr_clear = 1'b1;
                if (start) begin
                    state_d = RD_NUM;
                    pause_d = 1'b0;
                    rpn_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RD_NUM: begin
                state_d = WAIT_CNT;
                cnt_d   = '0;
            end
            WAIT_CNT: begin
                if (cnt_q == CNT_W'(COUNT_WAIT - 1)) begin
                    cnt_d = '0;
                    if (ref_particle_count == '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d  = SWEEP;
                        count_d  = ref_particle_count;
                        ctr_init = 1'b1;
                        pause_d  = stall;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SWEEP: begin
                if (pause_q) begin
                    pause_d = stall;
                end else if (last_pair) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    ctr_adv = 1'b1;
                    pause_d = stall;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                ctr_clear = 1'b1;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                ctr_clear = 1'b1;
            end
        endcase
    end

    // State and control output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            pause_q <= 1'b1;
            rpn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            pause_q <= pause_d;
            rpn_q   <= rpn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pause_reading        = pause_q;
    assign reading_particle_num = rpn_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_pos_read_controller.sv
// Directed bench for pos_read_controller.
// Scoreboard holds the expected (ref, particle, phase) read order.
module tb_pos_read_controller;

    localparam int W  = 7;
    localparam int NF = 7;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NF-1:0] back_pressure;
    logic [W-1:0]  ref_particle_count;
    logic          phase;
    logic          pause_reading;
    logic          reading_particle_num;
    logic [W-1:0]  particle_id;
    logic [W-1:0]  ref_id;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [2*W:0] last_rd = '0;
    logic [2*W:0] sb[$];

    pos_read_controller #(
        .PARTICLE_ID_WIDTH (W),
        .NUM_FILTER        (NF),
        .COUNT_WAIT        (2),
        .DRAIN_CYCLES      (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .back_pressure        (back_pressure),
        .ref_particle_count   (ref_particle_count),
        .phase                (phase),
        .pause_reading        (pause_reading),
        .reading_particle_num (reading_particle_num),
        .particle_id          (particle_id),
        .ref_id               (ref_id),
        .busy                 (busy),
        .done                 (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Scoreboard compare on every valid issued read.
    always @(negedge clk) begin
        if (rst && busy && !pause_reading
            && !reading_particle_num) begin
            vcnt++;
            last_rd = {ref_id, particle_id, phase};
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL extra_read observed=%0h expected=none",
                       last_rd);
            end
            if (sb.size() != 0)
                chk("read", 32'(last_rd), 32'(sb.pop_front()));
        end
        if (rst && reading_particle_num)
            chk("rpn_addr", 32'({particle_id, ref_id}), 32'd0);
        if (rst && done)
            done_cnt++;
    end

    task automatic load(input int n);
        total++;
        assert (n <= (1 << W) - 2) else begin
            bad++;
            $error("FAIL illegal_count observed=%0d expected<=%0d",
                   n, (1 << W) - 2);
        end
        ref_particle_count = W'(n);
        vcnt = 0;
        for (int r = 1; r <= n; r++)
            for (int p = 1; p <= n; p++)
                for (int h = 0; h < 2; h++)
                    sb.push_back({W'(r), W'(p), h[0]});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        exp_done++;
    endtask

    task automatic wait_addr(input int r, input int p,
                             input int h, input int budget);
        int n = 0;
        while (!(!pause_reading && busy && ref_id == W'(r)
                 && particle_id == W'(p) && phase == h[0])
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("addr_reached", 32'(n < budget), 32'd1);
    endtask

    task automatic run_timeline(input int n);
        int len = 8 + 2 * n * n;
        int se  = 3 + 2 * n * n;
        logic ep;
        load(n);
        pulse_start();
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            ep = (i == 0) ? 1'b0 : (i < 3) ? 1'b1
               : (i < se) ? 1'b0 : 1'b1;
            chk("busy", 32'(busy), 32'd1);
            chk("rpn", 32'(reading_particle_num), 32'(i == 0));
            chk("pause", 32'(pause_reading), 32'(ep));
            chk("done", 32'(done), 32'(i == len - 1));
        end
        exp_done++;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_ids", 32'({ref_id, particle_id}), 32'd0);
        chk("vcnt", 32'(vcnt), 32'(2 * n * n));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_cnt", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        back_pressure = '0;
        ref_particle_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_pause", 32'(pause_reading), 32'd1);
        chk("rst_busy", 32'({busy, done}), 32'd0);
        chk("rst_ids", 32'({ref_id, particle_id, phase,
                            reading_particle_num}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_timeline(3);
        chk("last_rd3", 32'(last_rd), 32'({W'(3), W'(3), 1'b1}));

        run_timeline(0);

        load(2);
        pulse_start();
        wait_addr(1, 1, 1, 20);
        back_pressure[5] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_pause", 32'(pause_reading), 32'd1);
            chk("stall_addr",
                32'({ref_id, particle_id, phase}),
                32'({W'(1), W'(2), 1'b0}));
        end
        back_pressure = '0;
        @(negedge clk);
        chk("reissue_pause", 32'(pause_reading), 32'd0);
        chk("reissue_addr", 32'({ref_id, particle_id, phase}),
            32'({W'(1), W'(2), 1'b0}));
        wait_done(40);
        chk("stall_vcnt", 32'(vcnt), 32'd8);
        chk("stall_sb", 32'(sb.size()), 32'd0);

        load(3);
        pulse_start();
        wait_addr(2, 1, 1, 60);
        #2 rst = 1'b0;
        #1;
        chk("arst_pause", 32'(pause_reading), 32'd1);
        chk("arst_busy", 32'({busy, done}), 32'd0);
        chk("arst_ids", 32'({ref_id, particle_id, phase,
                             reading_particle_num}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_nodone", 32'(done_cnt), 32'(exp_done));
        chk("arst_idle", 32'(busy), 32'd0);
        run_timeline(3);

        load(2);
        pulse_start();
        wait_addr(2, 1, 0, 30);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (sb.size() != 0 && n < 30) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        @(negedge clk);
        chk("drain_pause", 32'(pause_reading), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        repeat (10) @(negedge clk);
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_done_cnt", 32'(done_cnt), 32'(exp_done));
        chk("ign_vcnt", 32'(vcnt), 32'd8);

        run_timeline(126);
        chk("last_rd126", 32'(last_rd),
            32'({W'(126), W'(126), 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
